// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding access to a word-wide data memory.
// Sub-word stores are read-modify-write; bad requests never touch memory.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t state, state_n;

  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic        err_q;

  logic        illegal;
  logic        misal;
  logic        bad;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  always_comb begin
    illegal = (funct3 == 3'b011)
            | (funct3[2:1] == 2'b11)
            | (we & funct3[2]);
    misal = ((funct3[1:0] == 2'b01) & addr[0])
          | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    bad = illegal | misal;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (bad)
            state_n = DONE;
          else if (we && funct3[1:0] == 2'b10)
            state_n = WRITE;
          else
            state_n = READ;
        end
      end
      READ:    state_n = we_q ? WRITE : DONE;
      WRITE:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    byte_v = mem_rd[{addr_q[1:0], 3'b000} +: 8];
    half_v = mem_rd[{addr_q[1], 4'b0000} +: 16];
    unique case (f3_q)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b100:  load_val = {24'd0, byte_v};
      3'b101:  load_val = {16'd0, half_v};
      default: load_val = mem_rd;
    endcase
  end

  always_comb begin
    merge_val = mem_rd;
    if (f3_q[1:0] == 2'b00)
      merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      merge_q <= 32'd0;
      err_q   <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      if (state == IDLE && req) begin
        we_q    <= we;
        f3_q    <= funct3;
        addr_q  <= addr;
        wdata_q <= wdata;
        err_q   <= bad;
      end
      if (state == READ) begin
        if (we_q)
          merge_q <= merge_val;
        else
          rdata <= load_val;
      end
    end
  end

  // Outputs decode from state so reset clears them asynchronously
  always_comb begin
    busy   = (state != IDLE);
    done   = (state == DONE);
    err    = (state == DONE) & err_q;
    mem_we = (state == WRITE);
    mem_a  = {addr_q[31:2], 2'b00};
    mem_wd = (f3_q[1:0] == 2'b10) ? wdata_q : merge_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
// Vectors carry hand-computed results, latencies and write data.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:255];
  logic        pre_en;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;

  int checks;
  int errors;

  load_store_unit dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .funct3 (funct3),
    .addr   (addr),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .rdata  (rdata),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[9:2]];

  always @(posedge clk) begin
    if (mem_we)
      mem[mem_a[9:2]] <= mem_wd;
    else if (pre_en)
      mem[pre_idx] <= pre_val;
  end

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_dc;
    int          exp_wc;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] v);
    @(posedge clk);
    #1;
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = v;
    @(posedge clk);
    #1;
    pre_en = 1'b0;
  endtask

  task automatic run_op(input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d,
                        output int dc, output logic ev,
                        output int wc, output int nw,
                        output logic [31:0] wd, output int nd);
    @(posedge clk);
    #1;
    req    = 1'b1;
    we     = w;
    funct3 = f;
    addr   = a;
    wdata  = d;
    @(posedge clk);
    #1;
    req = 1'b0;
    dc = 0;
    ev = 1'b0;
    wc = 0;
    nw = 0;
    wd = 32'd0;
    nd = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (dc == 0) begin
          dc = c;
          ev = err;
        end
      end
      if (mem_we) begin
        nw++;
        wc = c;
        wd = mem_wd;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int          dc;
    int          wc;
    int          nw;
    int          nd;
    logic        ev;
    logic [31:0] wd;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = 1'b0;
    we     = 1'b0;
    funct3 = 3'b000;
    addr   = 32'd0;
    wdata  = 32'd0;
    pre_en = 1'b0;
    pre_idx = 8'd0;
    pre_val = 32'd0;

    vecs[0]  = '{1'b0, 3'b000, 32'h101, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0, 32'h0};
    vecs[1]  = '{1'b0, 3'b100, 32'h101, 32'h0, 32'h000000AA, 1'b0, 2, 0, 32'h0};
    vecs[2]  = '{1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF8899, 1'b0, 2, 0, 32'h0};
    vecs[3]  = '{1'b0, 3'b101, 32'h102, 32'h0, 32'h00008899, 1'b0, 2, 0, 32'h0};
    vecs[4]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 2, 0, 32'h0};
    vecs[5]  = '{1'b1, 3'b010, 32'h102, 32'h11111111, 32'h8899AABB, 1'b1, 1, 0, 32'h0};
    vecs[6]  = '{1'b0, 3'b001, 32'h101, 32'h0, 32'h8899AABB, 1'b1, 1, 0, 32'h0};
    vecs[7]  = '{1'b0, 3'b011, 32'h100, 32'h0, 32'h8899AABB, 1'b1, 1, 0, 32'h0};
    vecs[8]  = '{1'b1, 3'b000, 32'h103, 32'h12345677, 32'h8899AABB, 1'b0, 3, 2, 32'h7799AABB};
    vecs[9]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'h7799AABB, 1'b0, 2, 0, 32'h0};
    vecs[10] = '{1'b1, 3'b001, 32'h102, 32'hCAFE1234, 32'h7799AABB, 1'b0, 3, 2, 32'h1234AABB};
    vecs[11] = '{1'b0, 3'b101, 32'h102, 32'h0, 32'h00001234, 1'b0, 2, 0, 32'h0};
    vecs[12] = '{1'b0, 3'b000, 32'h100, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 0, 32'h0};
    vecs[13] = '{1'b1, 3'b010, 32'h104, 32'h01020304, 32'hFFFFFFBB, 1'b0, 2, 1, 32'h01020304};
    vecs[14] = '{1'b0, 3'b010, 32'h104, 32'h0, 32'h01020304, 1'b0, 2, 0, 32'h0};
    vecs[15] = '{1'b1, 3'b100, 32'h104, 32'hFFFFFFFF, 32'h01020304, 1'b1, 1, 0, 32'h0};

    #2;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    preload(8'h40, 32'h8899AABB);

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].w, vecs[i].f3, vecs[i].a, vecs[i].d,
             dc, ev, wc, nw, wd, nd);
      chk($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_dc);
      chk($sformatf("v%0d_done_count", i), nd, 1);
      chk($sformatf("v%0d_err", i), {31'd0, ev}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rd);
      chk($sformatf("v%0d_write_cycle", i), wc, vecs[i].exp_wc);
      chk($sformatf("v%0d_write_count", i), nw,
          (vecs[i].exp_wc != 0) ? 1 : 0);
      if (vecs[i].exp_wc != 0)
        chk($sformatf("v%0d_mem_wd", i), wd, vecs[i].exp_wd);
    end

    // Reset during the WRITE cycle of a W store must abandon it
    preload(8'h40, 32'h8899AABB);
    @(posedge clk);
    #1;
    req    = 1'b1;
    we     = 1'b1;
    funct3 = 3'b010;
    addr   = 32'h100;
    wdata  = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req = 1'b0;
    #1;
    chk("rstw_mem_we_before", {31'd0, mem_we}, 32'd1);
    chk("rstw_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    chk("rstw_done", {31'd0, done}, 32'd0);
    chk("rstw_rdata", rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(1'b0, 3'b010, 32'h100, 32'h0, dc, ev, wc, nw, wd, nd);
    chk("rstw_lw_rdata", rdata, 32'h8899AABB);
    chk("rstw_lw_done_cycle", dc, 2);

    // req held high while busy: only the first request is taken
    @(posedge clk);
    #1;
    req    = 1'b1;
    we     = 1'b0;
    funct3 = 3'b010;
    addr   = 32'h104;
    wdata  = 32'h0;
    nd = 0;
    dc = 0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      if (c == 1)
        addr = 32'h100;
      if (c == 3)
        req = 1'b0;
      @(negedge clk);
      if (done) begin
        nd++;
        if (dc == 0)
          dc = c;
      end
      if (c == 1 || c == 2)
        chk($sformatf("hold_busy_c%0d", c), {31'd0, busy}, 32'd1);
    end
    chk("hold_done_count", nd, 1);
    chk("hold_done_cycle", dc, 2);
    chk("hold_rdata", rdata, 32'h01020304);
    chk("hold_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side memory access unit between the core's execute stage and the byte-addressed, word-wide data memory, which has a combinational read and a synchronous write.
- Accepts one load or store request at a time with a RISC-V-style size/sign code.
- Performs aligned word accesses on the memory port.
- Extracts and sign/zero-extends sub-word loads.
- Implements byte/halfword stores as read-modify-write.
- Reports misaligned or illegal requests without touching memory.

## Interface
Parameters:
- none (address and data fixed at 32 bits; memory little-endian, byte k of a word at bits [8k+7:8k])

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  1  request strobe; sampled only when busy=0
- we  in  1  1 = store, 0 = load
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 only for stores
- addr  in  32  byte address
- wdata  in  32  store data; low byte/half used for SB/SH
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = misaligned or illegal funct3
- rdata  out  32  load result; updated only on successful load completion, held otherwise
- mem_we  out  1  memory write enable
- mem_a  out  32  memory address, always {addr_q[31:2],2'b00}
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data (combinational from mem_a)

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE with req=1 latches we, funct3, addr, wdata into _q registers. The next state is:
  - DONE with err set, if illegal or misaligned;
  - READ, for a load or a B/H store;
  - WRITE, for a W store.
- Illegal: funct3 011/110/111, or store with funct3[2]=1.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠00.
- READ samples mem_rd at the clock edge.
  - Load: rdata ← extracted value, next state DONE.
  - B/H store: merge register ← mem_rd with the target byte/half replaced by wdata_q[7:0]/[15:0], next state WRITE.
- Load extraction:
  - Byte = mem_rd[8·addr[1:0] +: 8].
  - Half = mem_rd[16·addr[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend.
- WRITE: mem_we=1 for exactly this cycle.
  - mem_wd = wdata_q for W, merge register for B/H.
  - Next state DONE.
- DONE: done=1, err as latched; next state IDLE.
- mem_we is decoded from state only; it is never high outside WRITE.
- req is ignored while busy=1; no queuing.
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, err=0, rdata=0, mem_we=0 immediately;
  - the in-flight access is abandoned;
  - a write is not committed unless the clock edge ended WRITE before rst asserted.

## Timing
- Cycle 0 = the cycle in which req is sampled in IDLE.
- Load: READ in cycle 1, done and rdata valid in cycle 2.
- W store: WRITE in cycle 1, memory updated at the end of cycle 1, done in cycle 2.
- B/H store: READ in cycle 1, WRITE in cycle 2, done in cycle 3.
- Error: done=1, err=1 in cycle 1; zero memory reads or writes.
- Earliest next request is in the cycle after DONE (IDLE).
  - Back-to-back throughput: 1 request per 3 cycles for loads and W stores.
  - 1 request per 4 cycles for B/H stores.
- mem_a is stable from cycle 1 until return to IDLE.

## Test plan
Preload: word 0x8899AABB at 0x100.
- LB 0x101, then LBU 0x101 -> rdata 0xFFFFFFAA, then 0x000000AA. Each with done in cycle 2, err=0, mem_we never high.
- LH 0x102, then LHU 0x102 -> rdata 0xFFFF8899, then 0x00008899. LW 0x100 -> 0x8899AABB.
- SB 0x103 with wdata 0x12345677 -> mem_we high only in cycle 2 with mem_wd 0x7799AABB. Done in cycle 3. A following LW 0x100 returns 0x7799AABB.
- SW 0x102, then LH 0x101, then funct3 011 -> each gives done and err=1 in cycle 1. mem_we stays 0, memory unchanged, rdata unchanged.
- SW 0x100 with wdata 0xDEADBEEF, rst asserted mid-cycle 1 -> mem_we, busy, done drop immediately. LW 0x100 after reset returns 0x8899AABB.
- Second req held high during a busy load -> ignored. Exactly one done per accepted request; new request is accepted only in IDLE.
